data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised, multi-cycle data memory for the MIPS datapath load/store stage.
- Successor to the single-cycle word memory; adds:
  - byte, halfword and word (and doubleword when 64-bit) accesses;
  - sign/zero extension of loads;
  - per-byte write lanes;
  - programmable wait states with a valid/ready request handshake;
  - out-of-range error reporting.
- Sits between the EX/MEM pipeline register and the pipeline stall logic; `busy` feeds the hazard unit.

Parameters:
- DATA_W, 32: memory word width in bits; legal values are 32 or 64.
- DEPTH, 256: number of DATA_W words; must be a power of two and at least 2.
- ADDR_W, 32: width of the byte address.
- WAIT_STATES, 1: extra cycles per access; legal range 0..7.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst_n, input, 1: synchronous reset, active low.
- req_valid, input, 1: request present.
- req_ready, output, 1: controller can accept a request this cycle.
- req_write, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = doubleword (legal only when DATA_W = 64).
- req_signed, input, 1: loads only; 1 = sign-extend, 0 = zero-extend.
- address, input, ADDR_W: byte address.
- write_data, input, DATA_W: store data, right-aligned (LSBs hold the stored item).
- rsp_valid, output, 1: one-cycle pulse that completes an access.
- rsp_data, output, DATA_W: load result, extended to DATA_W; 0 for stores and errors.
- rsp_err, output, 1: qualified by rsp_valid; the access was rejected.
- busy, output, 1: high while an accepted request is outstanding.

Behaviour:
- Interface decision: one clock (`clk`); reset (`rst_n`) is synchronous and active-low.
- While rst_n = 0 at a clock edge:
  - state goes to IDLE;
  - rsp_valid, rsp_err, busy and rsp_data are cleared to 0;
  - req_ready is 0.
  - req_ready is 1 on the first cycle after rst_n returns high.
  - Memory contents are not reset.
- FSM states:
  - IDLE: req_ready = 1, busy = 0.
  - WAIT: req_ready = 0, busy = 1; down-counter loaded with WAIT_STATES.
  - DONE: rsp_valid = 1, req_ready = 1, busy = 0.
- Request fields are captured at the accept edge (req_valid & req_ready). Inputs are don't-care at all other times.
- Transitions from IDLE or DONE:
  - on accept with WAIT_STATES > 0 → WAIT;
  - on accept with WAIT_STATES = 0 → DONE;
  - with no accept → IDLE.
- WAIT → DONE on the edge where the counter reaches 0.
- Latency: rsp_valid is high exactly WAIT_STATES+1 cycles after the accept edge. Back-to-back throughput is one access per WAIT_STATES+1 cycles. There is no response back-pressure.
- A new request accepted during DONE is independent of the completing access. Its fields may change on the same edge.
- Addressing:
  - little-endian byte lanes;
  - word index = address >> log2(DATA_W/8);
  - byte offset = low log2(DATA_W/8) bits of address.
- Range check: if address ≥ DEPTH*DATA_W/8, rsp_err = 1, the store is suppressed and rsp_data = 0. There is no wrap-around.
- Stores:
  - only the lanes selected by size and offset are written;
  - all other bytes of the word are preserved;
  - the write commits on the edge that enters DONE.
- Loads:
  - memory is read on the edge that enters DONE, so rsp_data reflects all earlier committed stores;
  - the selected bytes are right-aligned, then sign- or zero-extended per req_signed.
- Size 11 with DATA_W = 32 → rsp_err = 1, no write, rsp_data = 0.
- Reset asserted mid-access aborts the access: no write commits and no rsp_valid is produced.
- rsp_data and rsp_err hold their values after rsp_valid falls, until the next response or reset.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: an access whose offset is not a multiple of the size in bytes completes with rsp_err = 1, no write and rsp_data = 0.
- Undefined: offset bits below the access size are ignored; the address is forced down to natural alignment and the access completes normally with rsp_err = 0.

Test Plan:
1. Reset, then a word store of 0x0000_0007 to address 0x14, then a word load from 0x14, with WAIT_STATES = 1:
   - each rsp_valid comes 2 cycles after its accept;
   - the load returns rsp_data = 0x0000_0007, rsp_err = 0.
2. Word store of 0x1122_3344 to 0x20, then byte store of 0xAA to 0x21, then word load from 0x20 → rsp_data = 0x1122_AA44.
3. Store 0x0000_80F0 as a halfword to 0x30:
   - signed halfword load from 0x30 → 0xFFFF_80F0;
   - unsigned halfword load → 0x0000_80F0;
   - signed byte load from 0x31 → 0xFFFF_FF80.
4. Store to address DEPTH*4 (0x400 with defaults) → rsp_err = 1. A following word load from 0x000 returns its prior contents unchanged.
5. Hold req_valid high for 3 back-to-back loads with WAIT_STATES = 0 → rsp_valid is high on 3 consecutive cycles and req_ready stays 1.
6. Drive rst_n = 0 during WAIT of a store to 0x40:
   - no rsp_valid is produced;
   - a later load from 0x40 returns the old value;
   - with DMEM_ALIGN_CHECK_EN defined, a word load from 0x42 gives rsp_err = 1.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Multi-cycle byte-addressable data memory for the load/store stage.
// Optional alignment checking is enabled with `define DMEM_ALIGN_CHECK_EN.
module data_memory_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int SPAN_W = OFF_W + IDX_W;
    localparam bit PASS   = (WAIT_STATES == 0);

    typedef logic [NB-1:0]     lane_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic [2:0] cnt;
    logic accept;
    logic commit;

    logic              cap_write;
    logic [1:0]        cap_size;
    logic              cap_signed;
    logic [ADDR_W-1:0] cap_addr;
    word_t             cap_wdata;

    logic              acc_write;
    logic [1:0]        acc_size;
    logic              acc_signed;
    logic [ADDR_W-1:0] acc_addr;
    word_t             acc_wdata;

    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] lo_mask;
    logic [OFF_W-1:0] aoff;
    logic [IDX_W-1:0] idx;
    logic size_bad;
    logic range_bad;
    logic align_bad;
    logic err;
    lane_t base;
    lane_t wmask;
    word_t wshift;
    word_t rshift;
    word_t keep;
    word_t top;
    word_t ext;
    logic [6:0] nbits;
    logic neg;

    word_t mem [DEPTH];

    assign accept = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_nxt = PASS ? S_DONE : S_WAIT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == 3'd1) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = rst_n && (state != S_WAIT);
        busy      = (state == S_WAIT);
        rsp_valid = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 3'd0;
        end else if (accept) begin
            cnt <= 3'(WAIT_STATES);
        end else if (state == S_WAIT) begin
            cnt <= cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_write  <= req_write;
            cap_size   <= req_size;
            cap_signed <= req_signed;
            cap_addr   <= address;
            cap_wdata  <= write_data;
        end
    end

    // With no wait states the access commits on the accept edge itself.
    always_comb begin
        acc_write  = PASS ? req_write  : cap_write;
        acc_size   = PASS ? req_size   : cap_size;
        acc_signed = PASS ? req_signed : cap_signed;
        acc_addr   = PASS ? address    : cap_addr;
        acc_wdata  = PASS ? write_data : cap_wdata;
    end

    assign commit = rst_n && (state_nxt == S_DONE);

    always_comb begin
        off       = acc_addr[OFF_W-1:0];
        idx       = acc_addr[SPAN_W-1:OFF_W];
        lo_mask   = OFF_W'((32'd1 << acc_size) - 32'd1);
        aoff      = off & ~lo_mask;
        size_bad  = (acc_size == 2'b11) && (NB < 8);
        range_bad = (acc_addr >> SPAN_W) != '0;
`ifdef DMEM_ALIGN_CHECK_EN
        align_bad = (off & lo_mask) != '0;
`else
        align_bad = 1'b0;
`endif
        err = size_bad | range_bad | align_bad;
    end

    always_comb begin
        base = lane_t'(8'hFF);
        unique case (acc_size)
            2'b00: base = lane_t'(8'h01);
            2'b01: base = lane_t'(8'h03);
            2'b10: base = lane_t'(8'h0F);
            default: base = lane_t'(8'hFF);
        endcase
        wmask  = base << aoff;
        wshift = acc_wdata << {aoff, 3'b000};
        rshift = mem[idx] >> {aoff, 3'b000};
    end

    // Keep the low nbits of the aligned word, then fill above by sign.
    always_comb begin
        nbits = 7'd8 << acc_size;
        if (nbits >= 7'(DATA_W)) begin
            keep = '1;
        end else begin
            keep = (word_t'(1) << nbits) - word_t'(1);
        end
        top = word_t'(1) << (nbits - 7'd1);
        neg = acc_signed && ((rshift & top) != '0);
        ext = (rshift & keep) | (neg ? ~keep : '0);
    end

    always_ff @(posedge clk) begin
        if (commit && acc_write && !err) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) begin
                    mem[idx][8*b +: 8] <= wshift[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (commit) begin
            rsp_err  <= err;
            rsp_data <= (err || acc_write) ? '0 : ext;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: vector table on a one-wait-state
// instance plus back-to-back and reset-abort sequences.
module tb_data_memory_ctrl;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit AC = 1'b1;
`else
    localparam bit AC = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_write, a_signed;
    logic        a_rvalid, a_err, a_busy;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata;

    logic        b_valid, b_ready, b_write, b_signed;
    logic        b_rvalid, b_err, b_busy;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata;

    data_memory_ctrl #(.WAIT_STATES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_valid), .req_ready(a_ready),
        .req_write(a_write), .req_size(a_size),
        .req_signed(a_signed), .address(a_addr),
        .write_data(a_wdata), .rsp_valid(a_rvalid),
        .rsp_data(a_rdata), .rsp_err(a_err), .busy(a_busy)
    );

    data_memory_ctrl #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready),
        .req_write(b_write), .req_size(b_size),
        .req_signed(b_signed), .address(b_addr),
        .write_data(b_wdata), .rsp_valid(b_rvalid),
        .rsp_data(b_rdata), .rsp_err(b_err), .busy(b_busy)
    );

    int total = 0;
    int bad = 0;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] ed,
                       input logic ee);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr;
        v.wd = wd; v.ed = ed; v.ee = ee;
        vt.push_back(v);
    endtask

    task automatic run_a(input vec_t v, input int k);
        int lat;
        @(negedge clk);
        a_valid  = 1'b1;
        a_write  = v.wr;
        a_size   = v.sz;
        a_signed = v.sg;
        a_addr   = v.addr;
        a_wdata  = v.wd;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            a_valid = 1'b0;
            lat++;
        end while (!a_rvalid && lat < 20);
        chk($sformatf("v%0d latency", k), 32'(lat), 32'd2);
        chk($sformatf("v%0d data", k), a_rdata, v.ed);
        chk($sformatf("v%0d err", k), 32'(a_err), 32'(v.ee));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t bv[6];
        vec_t v;
        logic saw;

        rst_n = 1'b0;
        a_valid = 1'b0; a_write = 1'b0; a_size = 2'b10;
        a_signed = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_write = 1'b0; b_size = 2'b10;
        b_signed = 1'b0; b_addr = '0; b_wdata = '0;

        repeat (3) @(negedge clk);
        chk("reset ready", 32'(a_ready), 32'd0);
        chk("reset busy", 32'(a_busy), 32'd0);
        chk("reset valid", 32'(a_rvalid), 32'd0);
        chk("reset data", a_rdata, 32'd0);
        chk("reset err", 32'(a_err), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready after reset", 32'(a_ready), 32'd1);

        add(1, 2'd2, 0, 32'h14, 32'h0000_0007, 32'h0, 0);
        add(0, 2'd2, 0, 32'h14, 32'h0, 32'h0000_0007, 0);
        add(1, 2'd2, 0, 32'h20, 32'h1122_3344, 32'h0, 0);
        add(1, 2'd0, 0, 32'h21, 32'h0000_00AA, 32'h0, 0);
        add(0, 2'd2, 0, 32'h20, 32'h0, 32'h1122_AA44, 0);
        add(1, 2'd1, 0, 32'h30, 32'h0000_80F0, 32'h0, 0);
        add(0, 2'd1, 1, 32'h30, 32'h0, 32'hFFFF_80F0, 0);
        add(0, 2'd1, 0, 32'h30, 32'h0, 32'h0000_80F0, 0);
        add(0, 2'd0, 1, 32'h31, 32'h0, 32'hFFFF_FF80, 0);
        add(0, 2'd0, 0, 32'h31, 32'h0, 32'h0000_0080, 0);
        add(1, 2'd2, 0, 32'h00, 32'hCAFE_BABE, 32'h0, 0);
        add(1, 2'd2, 0, 32'h400, 32'h1234_5678, 32'h0, 1);
        add(0, 2'd2, 0, 32'h00, 32'h0, 32'hCAFE_BABE, 0);
        add(1, 2'd2, 0, 32'h3FC, 32'hA5A5_5A5A, 32'h0, 0);
        add(0, 2'd2, 0, 32'h3FC, 32'h0, 32'hA5A5_5A5A, 0);
        add(0, 2'd0, 1, 32'h3FF, 32'h0, 32'hFFFF_FFA5, 0);
        add(0, 2'd2, 0, 32'h401, 32'h0, 32'h0, 1);
        add(0, 2'd3, 0, 32'h20, 32'h0, 32'h0, 1);
        add(1, 2'd3, 0, 32'h00, 32'h0, 32'h0, 1);
        add(0, 2'd2, 0, 32'h00, 32'h0, 32'hCAFE_BABE, 0);
        add(0, 2'd2, 0, 32'h22, 32'h0, AC ? 32'h0 : 32'h1122_AA44, AC);
        add(0, 2'd1, 0, 32'h23, 32'h0, AC ? 32'h0 : 32'h0000_1122, AC);
        add(1, 2'd2, 0, 32'h24, 32'h0, 32'h0, 0);
        add(1, 2'd0, 0, 32'h26, 32'hDEAD_BE77, 32'h0, 0);
        add(0, 2'd2, 0, 32'h24, 32'h0, 32'h0077_0000, 0);
        add(1, 2'd1, 0, 32'h24, 32'h0000_BEEF, 32'h0, 0);
        add(0, 2'd2, 0, 32'h24, 32'h0, 32'h0077_BEEF, 0);
        add(1, 2'd2, 0, 32'h40, 32'h0BAD_F00D, 32'h0, 0);

        foreach (vt[k]) run_a(vt[k], k);

        // Zero wait states: six accesses with req_valid held high.
        bv[0] = '{1, 2'd2, 0, 32'h0, 32'h1111_1111, 32'h0, 0};
        bv[1] = '{1, 2'd2, 0, 32'h4, 32'h2222_2222, 32'h0, 0};
        bv[2] = '{1, 2'd2, 0, 32'h8, 32'h3333_3333, 32'h0, 0};
        bv[3] = '{0, 2'd2, 0, 32'h4, 32'h0, 32'h2222_2222, 0};
        bv[4] = '{0, 2'd2, 0, 32'h0, 32'h0, 32'h1111_1111, 0};
        bv[5] = '{0, 2'd0, 1, 32'hB, 32'h0, 32'h0000_0033, 0};
        @(negedge clk);
        b_valid = 1'b1;
        b_write = bv[0].wr; b_size = bv[0].sz; b_signed = bv[0].sg;
        b_addr = bv[0].addr; b_wdata = bv[0].wd;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d valid", i), 32'(b_rvalid), 32'd1);
            chk($sformatf("b2b%0d ready", i), 32'(b_ready), 32'd1);
            chk($sformatf("b2b%0d data", i), b_rdata, bv[i].ed);
            if (i < 5) begin
                v = bv[i+1];
                b_write = v.wr; b_size = v.sz; b_signed = v.sg;
                b_addr = v.addr; b_wdata = v.wd;
            end else begin
                b_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b valid drop", 32'(b_rvalid), 32'd0);

        // Reset during the wait state of a store must abort it.
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_size = 2'd2;
        a_signed = 1'b0; a_addr = 32'h40; a_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        chk("wait busy", 32'(a_busy), 32'd1);
        chk("wait ready", 32'(a_ready), 32'd0);
        rst_n = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw = saw | a_rvalid;
        end
        chk("abort no valid", 32'(saw), 32'd0);
        chk("abort ready low", 32'(a_ready), 32'd0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            saw = saw | a_rvalid;
        end
        chk("abort no late valid", 32'(saw), 32'd0);
        v = '{0, 2'd2, 0, 32'h40, 32'h0, 32'h0BAD_F00D, 0};
        run_a(v, 100);
        v = '{0, 2'd2, 0, 32'h42, 32'h0, AC ? 32'h0 : 32'h0BAD_F00D, AC};
        run_a(v, 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
